i2s_dac_tx: RTL and testbench

I2S transmit serializer for the codec DAC path. It is the output-side counterpart of the ADC deserializer in the codec wrapper. It accepts a filtered stereo sample pair through a valid/ready handshake, double-buffers it, and generates bclk/lrclk as I2S master. Each 24-bit word is shifted MSB-first onto ac_dac_sdata in standard I2S format. It sits between the filter chain output and the codec pins.

---
 rtl/audio_pkg.sv | 20 ++
 rtl/i2s_bclk_gen.sv | 44 ++++
 rtl/i2s_dac_tx.sv | 140 ++++++++++++++
 tb/tb_i2s_dac_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_pkg                                                            |
// | Shared audio sample widths and stereo sample types.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package audio_pkg;

  localparam int SAMPLE_W   = 24;
  localparam int I2S_SLOT_W = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

endpackage
`default_nettype wire

// File: rtl/i2s_bclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2s_bclk_gen                                                         |
// | Bit-clock divider; flags the clk cycle on which bclk falls.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2s_bclk_gen #(
  parameter int BCLK_HALF = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic bclk,
  output logic fall_stb
);

  localparam int C_DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(BCLK_HALF - 1);
  localparam logic [C_DIV_W-1:0] C_DIV_ONE  = C_DIV_W'(1);

  logic [C_DIV_W-1:0] r_div_cnt;
  logic               r_bclk;
  logic               w_terminal;

  assign w_terminal = enable && (r_div_cnt == C_DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_terminal) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + C_DIV_ONE;
    end
  end

  // Strobe coincides with the edge that drives bclk low.
  assign fall_stb = w_terminal && r_bclk;
  assign bclk     = r_bclk;

endmodule
`default_nettype wire

// File: rtl/i2s_dac_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2s_dac_tx                                                           |
// | I2S master transmitter: double-buffered stereo pair, MSB-first out.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int DATA_W    = SAMPLE_W,
  parameter int SLOT_W    = I2S_SLOT_W,
  parameter int BCLK_HALF = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] l_data,
  input  logic [DATA_W-1:0] r_data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              frame_start,
  output logic              underrun,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata
);

  localparam int C_FRAME_LEN = 2 * SLOT_W;
  localparam int C_CNT_W     = $clog2(C_FRAME_LEN);
  localparam int C_IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_FRAME_LEN - 1);
  localparam logic [C_CNT_W-1:0] C_SLOT = C_CNT_W'(SLOT_W);
  localparam logic [C_CNT_W-1:0] C_DATA = C_CNT_W'(DATA_W);
  localparam logic [C_CNT_W-1:0] C_ONE  = C_CNT_W'(1);

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  logic               w_fall;
  logic [C_CNT_W-1:0] r_bit_cnt;
  logic               r_lrclk;
  logic               r_sdata;
  logic               r_frame_start;
  logic               r_underrun;
  logic               r_hold_full;
  logic               r_data_ready;
  pair_t              r_hold;
  pair_t              r_frame;

  logic [C_CNT_W-1:0] w_bit_nxt;
  logic [C_CNT_W-1:0] w_pos;
  logic               w_boundary;
  logic               w_right;
  logic               w_accept;
  logic               w_sbit;
  pair_t              w_frame_nxt;
  logic [DATA_W-1:0]  w_word;

  i2s_bclk_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_bclk_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .bclk     (bclk),
    .fall_stb (w_fall)
  );

  assign w_accept = data_valid && r_data_ready;

  // Serial data is computed from the post-update position and frame so it
  // changes on the same edge as the bit counter.
  always_comb begin
    w_bit_nxt   = (r_bit_cnt == C_LAST) ? '0 : r_bit_cnt + C_ONE;
    w_boundary  = w_fall && (w_bit_nxt == '0);
    w_frame_nxt = (w_boundary && r_hold_full) ? r_hold : r_frame;
    w_right     = (w_bit_nxt >= C_SLOT);
    w_pos       = w_right ? (w_bit_nxt - C_SLOT) : w_bit_nxt;
    w_word      = w_right ? w_frame_nxt.r : w_frame_nxt.l;
    w_sbit      = 1'b0;
    if ((w_pos != '0) && (w_pos <= C_DATA)) begin
      w_sbit = w_word[C_IDX_W'(DATA_W - int'(w_pos))];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bit_cnt     <= C_LAST;
      r_lrclk       <= 1'b1;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_frame       <= '0;
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      if (!enable) begin
        r_bit_cnt <= C_LAST;
        r_lrclk   <= 1'b1;
        r_sdata   <= 1'b0;
      end else if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= w_right;
        r_sdata   <= w_sbit;
        r_frame   <= w_frame_nxt;
        if (w_boundary) begin
          r_frame_start <= 1'b1;
          r_underrun    <= !r_hold_full;
        end
      end
    end
  end

  // Accept and frame-load are exclusive: accept needs an empty holding buffer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hold_full  <= 1'b0;
      r_data_ready <= 1'b1;
      r_hold       <= '0;
    end else if (w_boundary && r_hold_full) begin
      r_hold_full  <= 1'b0;
      r_data_ready <= 1'b1;
    end else if (w_accept) begin
      r_hold.l     <= l_data;
      r_hold.r     <= r_data;
      r_hold_full  <= 1'b1;
      r_data_ready <= 1'b0;
    end
  end

  assign data_ready  = r_data_ready;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;
  assign lrclk       = r_lrclk;
  assign sdata       = r_sdata;

endmodule
`default_nettype wire

// File: tb/tb_i2s_dac_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_i2s_dac_tx                                                        |
// | Self-checking bench: cycle model, frame capture and stimulus table.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_i2s_dac_tx;

  localparam int BH        = 2;
  localparam int SW        = 32;
  localparam int DW        = 24;
  localparam int FRAME     = 2 * SW;
  localparam int FRAME_CLK = 2 * BH * FRAME;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          data_valid = 1'b0;
  logic [DW-1:0] l_data = '0;
  logic [DW-1:0] r_data = '0;
  logic          data_ready, frame_start, underrun, bclk, lrclk, sdata;

  always #5 clk = ~clk;

  i2s_dac_tx #(
    .DATA_W    (DW),
    .SLOT_W    (SW),
    .BCLK_HALF (BH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .l_data      (l_data),
    .r_data      (r_data),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .frame_start (frame_start),
    .underrun    (underrun),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata)
  );

  typedef struct {
    logic [DW-1:0]    l;
    logic [DW-1:0]    r;
    logic [FRAME-1:0] frame;
  } vec_t;

  typedef struct {
    logic [FRAME-1:0] bits;
    logic             ur;
  } cap_t;

  vec_t vecs[8];
  cap_t got[$];

  int checks = 0;
  int failures = 0;

  // Reference model state: cycles since enable, holding buffer, playing frame
  int            m_e = 0;
  logic          m_hold_v = 1'b0;
  logic [DW-1:0] m_hold_l = '0, m_hold_r = '0, m_frame_l = '0, m_frame_r = '0;
  logic          m_fs = 1'b0, m_ur = 1'b0, m_acc = 1'b0;

  logic             prev_bclk = 1'b0;
  logic             collecting = 1'b0;
  int               nbits = 0;
  logic [FRAME-1:0] cur_bits = '0;
  logic             cur_ur = 1'b0;

  function automatic bit is_boundary(int e);
    return (e >= 2 * BH) && (((e - 2 * BH) % FRAME_CLK) == 0);
  endfunction

  function automatic int slot_bit(int e);
    if (e < 2 * BH) return -1;
    return ((e - 2 * BH) / (2 * BH)) % FRAME;
  endfunction

  function automatic logic exp_sdata(int k, logic [DW-1:0] l, logic [DW-1:0] r);
    logic [DW-1:0] w;
    int p;
    if (k < 0) return 1'b0;
    p = k % SW;
    w = (k >= SW) ? r : l;
    if (p >= 1 && p <= DW) return w[DW-p];
    return 1'b0;
  endfunction

  function automatic logic [FRAME-1:0] mk_frame(logic [DW-1:0] l, logic [DW-1:0] r);
    return {1'b0, l, 7'd0, 1'b0, r, 7'd0};
  endfunction

  task automatic check(string name, logic [FRAME-1:0] act, logic [FRAME-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    int k;
    logic [5:0] exp_o;
    @(posedge clk);
    m_acc = 1'b0;
    if (!reset_n) begin
      m_e = 0; m_hold_v = 1'b0; m_fs = 1'b0; m_ur = 1'b0;
      m_hold_l = '0; m_hold_r = '0; m_frame_l = '0; m_frame_r = '0;
    end else begin
      m_acc = data_valid && !m_hold_v;
      m_e   = enable ? m_e + 1 : 0;
      m_fs  = enable && is_boundary(m_e);
      m_ur  = m_fs && !m_hold_v;
      if (m_fs && m_hold_v) begin
        m_frame_l = m_hold_l; m_frame_r = m_hold_r; m_hold_v = 1'b0;
      end
      if (m_acc) begin
        m_hold_l = l_data; m_hold_r = r_data; m_hold_v = 1'b1;
      end
    end
    #1;
    k = slot_bit(m_e);
    exp_o[5] = ((m_e / BH) % 2) == 1;
    exp_o[4] = (k < 0) ? 1'b1 : (k >= SW);
    exp_o[3] = exp_sdata(k, m_frame_l, m_frame_r);
    exp_o[2] = m_fs;
    exp_o[1] = m_ur;
    exp_o[0] = !m_hold_v;
    check("outputs{bclk,lrclk,sdata,fs,ur,ready}",
          {bclk, lrclk, sdata, frame_start, underrun, data_ready}, exp_o);
    if (!reset_n) collecting = 1'b0;
    if (frame_start) begin
      collecting = 1'b1; nbits = 0; cur_bits = '0; cur_ur = underrun;
    end else if (collecting && bclk && !prev_bclk) begin
      cur_bits = {cur_bits[FRAME-2:0], sdata};
      nbits++;
      if (nbits == FRAME) begin
        got.push_back('{cur_bits, cur_ur});
        collecting = 1'b0;
      end
    end
    prev_bclk = bclk;
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r, output int waited);
    int t = 0;
    l_data = l; r_data = r; data_valid = 1'b1;
    do begin
      tick(); t++;
    end while (!m_acc && t < 2 * FRAME_CLK);
    data_valid = 1'b0;
    check("accept", m_acc, 1);
    waited = t;
  endtask

  task automatic wait_frames(int n);
    int t = 0;
    while (got.size() < n && t < (n + 1) * FRAME_CLK) begin tick(); t++; end
    check("frames_arrived", got.size() >= n, 1);
  endtask

  task automatic wait_slot(int k);
    int t = 0;
    while (slot_bit(m_e) != k && t < 2 * FRAME_CLK) begin tick(); t++; end
    check("reach_slot_bit", slot_bit(m_e), k);
  endtask

  initial begin
    int w, t, played, last_pos, idx;

    vecs[0] = '{24'hABCDEF, 24'h123456, {1'b0, 24'hABCDEF, 7'd0, 1'b0, 24'h123456, 7'd0}};
    vecs[1] = '{24'h000001, 24'h800000, {1'b0, 24'h000001, 7'd0, 1'b0, 24'h800000, 7'd0}};
    vecs[2] = '{24'h7FFFFF, 24'hFFFFFF, {1'b0, 24'h7FFFFF, 7'd0, 1'b0, 24'hFFFFFF, 7'd0}};
    vecs[3] = '{24'hC3A50F, 24'h0F5AC3, {1'b0, 24'hC3A50F, 7'd0, 1'b0, 24'h0F5AC3, 7'd0}};
    for (int i = 4; i < 8; i++) begin
      vecs[i].l = DW'($urandom);
      vecs[i].r = DW'($urandom);
      vecs[i].frame = mk_frame(vecs[i].l, vecs[i].r);
    end

    // Reset state
    repeat (3) tick();
    check("reset_outputs", {bclk, lrclk, sdata, frame_start, underrun, data_ready}, 6'b010001);
    reset_n = 1'b1;
    tick();

    // Basic frame, then underrun replay
    send(vecs[0].l, vecs[0].r, w);
    enable = 1'b1;
    wait_frames(2);
    check("basic_frame_bits", got[0].bits, vecs[0].frame);
    check("basic_frame_no_underrun", got[0].ur, 0);
    check("underrun_replay_bits", got[1].bits, vecs[0].frame);
    check("underrun_flag", got[1].ur, 1);

    // Back-pressure with continuous valid
    got.delete();
    for (int i = 1; i <= 5; i++) begin
      send(vecs[i].l, vecs[i].r, w);
      if (i == 2) check("second_pair_held_off", w > 1, 1);
    end
    t = 0; played = 0;
    while (played < 5 && t < 7 * FRAME_CLK) begin
      tick(); t++;
      played = 0;
      foreach (got[j]) if (!got[j].ur) played++;
    end
    check("played_count", played, 5);
    idx = 1; last_pos = 0;
    foreach (got[j]) begin
      if (!got[j].ur && idx <= 5) begin
        check($sformatf("table_frame_%0d", idx), got[j].bits, vecs[idx].frame);
        idx++;
        last_pos = j;
      end
    end
    wait_frames(last_pos + 2);
    check("no_duplicate_after_last", got[last_pos + 1].ur, 1);
    check("replay_after_last", got[last_pos + 1].bits, vecs[5].frame);

    // Valid arriving exactly on a boundary with the holding buffer empty
    t = 0;
    while (!is_boundary(m_e + 1) && t < FRAME_CLK + 8) begin tick(); t++; end
    l_data = vecs[6].l; r_data = vecs[6].r; data_valid = 1'b1;
    got.delete();
    tick();
    data_valid = 1'b0;
    check("simul_underrun", underrun, 1);
    check("simul_frame_start", frame_start, 1);
    check("simul_ready_low", data_ready, 0);
    wait_frames(2);
    check("simul_old_replay", got[0].bits, vecs[5].frame);
    check("simul_old_flag", got[0].ur, 1);
    check("simul_new_frame", got[1].bits, vecs[6].frame);
    check("simul_new_flag", got[1].ur, 0);

    // Enable dropped mid-frame
    wait_slot(40);
    enable = 1'b0;
    tick();
    check("idle_outputs{bclk,lrclk,sdata}", {bclk, lrclk, sdata}, 3'b010);
    repeat (3) tick();
    enable = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!frame_start && t < 20);
    check("reenable_latency", t, 2 * BH);

    // Reset mid-frame discards the held pair
    send(vecs[7].l, vecs[7].r, w);
    wait_slot(10);
    reset_n = 1'b0;
    tick();
    check("midreset_outputs", {bclk, lrclk, sdata, frame_start, underrun, data_ready}, 6'b010001);
    reset_n = 1'b1;
    got.delete();
    wait_frames(1);
    check("post_reset_zero_frame", got[0].bits, '0);
    check("post_reset_underrun", got[0].ur, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
